evac_dispatch_ctrl: RTL and testbench

- Front-end and back-end controller for the 4-entry evacuation queue.
- Insert side: arbitrates between NUM_REQ zone-alert requesters and drives the queue's Insert/Zone/Priority inputs. Tracks occupancy so the queue is never over-written, because the queue itself has no full protection.
- Serve side: when a rescue unit signals readiness, pulses Serve, captures the head entry and holds it until the unit acknowledges.

---
 rtl/evac_dispatch_ctrl_if.sv | 35 +++
 rtl/evac_dispatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_evac_dispatch_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/evac_dispatch_ctrl_if.sv
// Requester, queue and rescue-unit signal bundle for evac_dispatch_ctrl.
// The controller attaches to the slave modport; the environment attaches to the master modport.
interface evac_dispatch_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   Req;
  logic [8*NUM_REQ-1:0] Req_Zone;
  logic [2*NUM_REQ-1:0] Req_Priority;
  logic [NUM_REQ-1:0]   Grant;
  logic                 Insert;
  logic [7:0]           Zone;
  logic [1:0]           Priority;
  logic                 Serve;
  logic [7:0]           Q_Zone;
  logic [1:0]           Q_Priority;
  logic                 Unit_Ready;
  logic                 Dispatch_Valid;
  logic [7:0]           Dispatch_Zone;
  logic [1:0]           Dispatch_Priority;
  logic                 Dispatch_Ack;
  logic [2:0]           Occupancy;
  logic                 Full;

  modport master (
    output Req, Req_Zone, Req_Priority, Q_Zone, Q_Priority, Unit_Ready, Dispatch_Ack,
    input  Grant, Insert, Zone, Priority, Serve, Dispatch_Valid, Dispatch_Zone,
           Dispatch_Priority, Occupancy, Full
  );

  modport slave (
    input  Req, Req_Zone, Req_Priority, Q_Zone, Q_Priority, Unit_Ready, Dispatch_Ack,
    output Grant, Insert, Zone, Priority, Serve, Dispatch_Valid, Dispatch_Zone,
           Dispatch_Priority, Occupancy, Full
  );
endinterface

// File: rtl/evac_dispatch_ctrl.sv
// Insert arbiter and serve/dispatch FSM for the 4-entry evacuation queue.
// Define EVAC_DISPATCH_AGING_EN to boost long-waiting requesters to priority 3.
module evac_dispatch_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AGE_LIMIT = 12
) (
  input logic                 Main_Clock,
  input logic                 Reset,
  evac_dispatch_ctrl_if.slave bus
);
  localparam int unsigned ZONE_W = 8;
  localparam int unsigned PRIO_W = 2;
  localparam int unsigned OCC_W  = 3;
  localparam int unsigned AGE_W  = 4;
  localparam int unsigned RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || DEPTH < 1 || DEPTH > 7 || AGE_LIMIT < 1 || AGE_LIMIT > 15)
  begin : g_bad_param
    $error("evac_dispatch_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_e;

  state_e              state_q;
  logic [RR_W-1:0]     rr_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                insert_q;
  logic [ZONE_W-1:0]   zone_q;
  logic [PRIO_W-1:0]   prio_q;
  logic                serve_q;
  logic                dvalid_q;
  logic [ZONE_W-1:0]   dzone_q;
  logic [PRIO_W-1:0]   dprio_q;
  logic [OCC_W-1:0]    occ_q;
  logic                full_q;

  logic [PRIO_W-1:0]   eff_prio [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic                win_found;
  logic [RR_W-1:0]     win_idx;
  logic [ZONE_W-1:0]   win_zone;
  logic [PRIO_W-1:0]   win_prio;
  logic [PRIO_W-1:0]   best_prio;
  logic [NUM_REQ-1:0]  grant_d;
  logic                serve_start;
  logic [OCC_W-1:0]    occ_d;

`ifdef EVAC_DISPATCH_AGING_EN
  logic [AGE_W-1:0] age_q [NUM_REQ];

  // Wait counters: count while requesting and not granted, saturating.
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.Req[i] || grant_d[i]) age_q[i] <= '0;
        else if (age_q[i] != '1)        age_q[i] <= age_q[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eff_prio[i] = (age_q[i] >= AGE_W'(AGE_LIMIT)) ? 2'd3 : bus.Req_Priority[i*PRIO_W +: PRIO_W];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) eff_prio[i] = bus.Req_Priority[i*PRIO_W +: PRIO_W];
  end
`endif

  // Highest effective priority wins; strict '>' keeps the first hit in RR order on ties.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    eligible  = bus.Req & {NUM_REQ{~full_q}};
    win_found = 1'b0;
    win_idx   = rr_q;
    win_zone  = '0;
    win_prio  = '0;
    best_prio = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (eligible[idx] && (!win_found || eff_prio[idx] > best_prio)) begin
        win_found = 1'b1;
        win_idx   = RR_W'(idx);
        best_prio = eff_prio[idx];
        win_zone  = bus.Req_Zone[idx*ZONE_W +: ZONE_W];
        win_prio  = bus.Req_Priority[idx*PRIO_W +: PRIO_W];
      end
    end
    grant_d     = win_found ? (NUM_REQ'(1) << win_idx) : '0;
    serve_start = (state_q == IDLE) && bus.Unit_Ready && (occ_q != '0);
    case ({win_found, serve_start})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      insert_q <= 1'b0;
      zone_q   <= '0;
      prio_q   <= '0;
      serve_q  <= 1'b0;
      dvalid_q <= 1'b0;
      dzone_q  <= '0;
      dprio_q  <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      insert_q <= win_found;
      if (win_found) begin
        zone_q <= win_zone;
        prio_q <= win_prio;
        rr_q   <= (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + RR_W'(1);
      end
      occ_q  <= occ_d;
      full_q <= (occ_d == OCC_W'(DEPTH));
      case (state_q)
        IDLE: begin
          if (serve_start) begin
            serve_q <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          // Queue head is valid during the Serve cycle; capture it at the closing edge.
          dzone_q  <= bus.Q_Zone;
          dprio_q  <= bus.Q_Priority;
          dvalid_q <= 1'b1;
          serve_q  <= 1'b0;
          state_q  <= DELIVER;
        end
        DELIVER: begin
          if (bus.Dispatch_Ack) begin
            dvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Grant             = grant_q;
  assign bus.Insert            = insert_q;
  assign bus.Zone              = zone_q;
  assign bus.Priority          = prio_q;
  assign bus.Serve             = serve_q;
  assign bus.Dispatch_Valid    = dvalid_q;
  assign bus.Dispatch_Zone     = dzone_q;
  assign bus.Dispatch_Priority = dprio_q;
  assign bus.Occupancy         = occ_q;
  assign bus.Full              = full_q;
endmodule

// File: tb/tb_evac_dispatch_ctrl.sv
// Directed bench for evac_dispatch_ctrl with a small FIFO standing in for the evacuation queue.
module tb_evac_dispatch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  evac_dispatch_ctrl_if #(.NUM_REQ(4)) bus();

  evac_dispatch_ctrl #(.NUM_REQ(4), .DEPTH(4), .AGE_LIMIT(3)) dut (
    .Main_Clock (clk),
    .Reset      (rst),
    .bus        (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Queue stand-in: push on Insert, pop on Serve, head shown combinationally.
  logic [7:0] qz [4];
  logic [1:0] qp [4];
  logic [1:0] qh;
  logic [2:0] qc;

  always @(posedge clk) begin
    if (rst) begin
      qh <= '0;
      qc <= '0;
    end else begin
      if (bus.Insert) begin
        qz[2'(qh + qc[1:0])] <= bus.Zone;
        qp[2'(qh + qc[1:0])] <= bus.Priority;
      end
      if (bus.Serve && qc != 0) qh <= qh + 2'd1;
      qc <= qc + 3'(bus.Insert) - 3'(bus.Serve && qc != 0);
    end
  end

  always_comb begin
    bus.Q_Zone     = qz[qh];
    bus.Q_Priority = qp[qh];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] z, input logic [1:0] p);
    bus.Req_Zone[i*8 +: 8]     = z;
    bus.Req_Priority[i*2 +: 2] = p;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},  32'(bus.Grant), 32'h0);
    chk({tag, "_insert"}, 32'(bus.Insert), 32'h0);
    chk({tag, "_serve"},  32'(bus.Serve), 32'h0);
    chk({tag, "_occ"},    32'(bus.Occupancy), 32'h0);
    chk({tag, "_valid"},  32'(bus.Dispatch_Valid), 32'h0);
  endtask

  // Wait (bounded) for a dispatch, check it, then acknowledge two cycles after valid.
  task automatic serve_one(input logic [7:0] ez, input string tag);
    int serves = 0;
    int n = 0;
    while (!bus.Dispatch_Valid && n < 20) begin
      if (bus.Serve) serves++;
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.Dispatch_Valid), 32'h1);
    chk({tag, "_zone"},  32'(bus.Dispatch_Zone), 32'(ez));
    chk({tag, "_serves"}, 32'(serves), 32'h1);
    tick();
    tick();
    bus.Dispatch_Ack = 1'b1;
    chk({tag, "_hold"}, 32'(bus.Dispatch_Zone), 32'(ez));
    tick();
    bus.Dispatch_Ack = 1'b0;
    chk({tag, "_cleared"}, 32'(bus.Dispatch_Valid), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g [4];
    logic [7:0] exp_z [4];
    int first0;
    int n1;
    int idle_serves;

    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    exp_z = '{8'h31, 8'h33, 8'h31, 8'h33};

    rst              = 1'b1;
    bus.Req          = 4'b1111;
    bus.Req_Zone     = '0;
    bus.Req_Priority = '0;
    bus.Unit_Ready   = 1'b0;
    bus.Dispatch_Ack = 1'b0;

    // Reset held two cycles with all requesters active.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle_outputs("reset");
    end
    rst     = 1'b0;
    bus.Req = '0;
    tick();
    chk_idle_outputs("release");

    // Higher priority requester 2 beats requester 0.
    set_req(0, 8'h10, 2'd1);
    set_req(2, 8'h2A, 2'd3);
    bus.Req = 4'b0101;
    tick();
    chk("prio_grant", 32'(bus.Grant), 32'h4);
    chk("prio_insert", 32'(bus.Insert), 32'h1);
    chk("prio_zone", 32'(bus.Zone), 32'h2A);
    chk("prio_prio", 32'(bus.Priority), 32'h3);
    chk("prio_occ", 32'(bus.Occupancy), 32'h1);
    bus.Req = '0;
    tick();
    chk("prio_pulse_grant", 32'(bus.Grant), 32'h0);
    chk("prio_pulse_insert", 32'(bus.Insert), 32'h0);
    chk("prio_pulse_occ", 32'(bus.Occupancy), 32'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Equal priorities alternate round-robin until the queue is full.
    set_req(1, 8'h31, 2'd2);
    set_req(3, 8'h33, 2'd2);
    bus.Req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_grant", 32'(bus.Grant), 32'(exp_g[i]));
      chk("rr_zone", 32'(bus.Zone), 32'(exp_z[i]));
      chk("rr_occ", 32'(bus.Occupancy), 32'(i + 1));
      chk("rr_full", 32'(bus.Full), (i == 3) ? 32'h1 : 32'h0);
    end
    tick();
    chk("full_grant", 32'(bus.Grant), 32'h0);
    chk("full_insert", 32'(bus.Insert), 32'h0);
    chk("full_occ", 32'(bus.Occupancy), 32'h4);

    // Full queue: serve frees a slot, then held Req0 is granted.
    set_req(0, 8'h44, 2'd0);
    bus.Req        = 4'b0001;
    bus.Unit_Ready = 1'b1;
    tick();
    chk("fq_serve", 32'(bus.Serve), 32'h1);
    chk("fq_nogrant", 32'(bus.Grant), 32'h0);
    chk("fq_occ3", 32'(bus.Occupancy), 32'h3);
    chk("fq_notfull", 32'(bus.Full), 32'h0);
    tick();
    chk("fq_grant0", 32'(bus.Grant), 32'h1);
    chk("fq_zone", 32'(bus.Zone), 32'h44);
    chk("fq_occ4", 32'(bus.Occupancy), 32'h4);
    chk("fq_full", 32'(bus.Full), 32'h1);
    chk("fq_serve_off", 32'(bus.Serve), 32'h0);
    chk("fq_valid", 32'(bus.Dispatch_Valid), 32'h1);
    chk("fq_dzone", 32'(bus.Dispatch_Zone), 32'h31);
    chk("fq_dprio", 32'(bus.Dispatch_Priority), 32'h2);
    bus.Req = '0;
    tick();
    chk("deliver_hold_valid", 32'(bus.Dispatch_Valid), 32'h1);
    chk("deliver_hold_zone", 32'(bus.Dispatch_Zone), 32'h31);
    chk("deliver_no_serve", 32'(bus.Serve), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("deliver_reset_valid", 32'(bus.Dispatch_Valid), 32'h0);
    chk("deliver_reset_occ", 32'(bus.Occupancy), 32'h0);

    // Load zones 11,22,33, then serve them in order.
    bus.Unit_Ready = 1'b0;
    bus.Req        = 4'b0001;
    set_req(0, 8'h11, 2'd1);
    tick();
    chk("load_grant", 32'(bus.Grant), 32'h1);
    chk("load_zone11", 32'(bus.Zone), 32'h11);
    set_req(0, 8'h22, 2'd1);
    tick();
    chk("load_zone22", 32'(bus.Zone), 32'h22);
    set_req(0, 8'h33, 2'd1);
    tick();
    chk("load_zone33", 32'(bus.Zone), 32'h33);
    chk("load_occ", 32'(bus.Occupancy), 32'h3);
    bus.Req        = '0;
    bus.Unit_Ready = 1'b1;
    serve_one(8'h11, "srv11");
    serve_one(8'h22, "srv22");
    serve_one(8'h33, "srv33");
    chk("drain_occ", 32'(bus.Occupancy), 32'h0);
    idle_serves = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Serve) idle_serves++;
    end
    chk("empty_no_serve", 32'(idle_serves), 32'h0);

    // Low-priority Req0 against a persistent priority-2 Req1.
    rst = 1'b1;
    tick();
    rst            = 1'b0;
    bus.Unit_Ready = 1'b0;
    set_req(0, 8'hA0, 2'd0);
    set_req(1, 8'hB1, 2'd2);
    bus.Req = 4'b0011;
    first0  = -1;
    n1      = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (bus.Grant[0] && first0 < 0) begin
        first0     = t;
        bus.Req[0] = 1'b0;
      end
      if (bus.Grant[1]) n1++;
    end
`ifdef EVAC_DISPATCH_AGING_EN
    chk("age_first_grant0", 32'(first0), 32'd4);
    chk("age_req1_grants", 32'(n1), 32'd3);
`else
    chk("noage_grant0", 32'(first0), 32'hFFFF_FFFF);
    chk("noage_req1_grants", 32'(n1), 32'd4);
`endif
    chk("age_full", 32'(bus.Full), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
